keypad_scan_ctrl: RTL
=====================

// Module: keypad_scan_ctrl
// PURPOSE
//  Single-clock 4x4 keypad scan controller. Replaces the derived-clock scan path with a
//  clock-enable tick. Drives columns, synchronises and debounces rows, and queues one
//  code per debounced press into a FIFO that the CPU drains over a valid/ready handshake.
//  Sits between the keypad pins and the CPU I/O register decode.
// PARAMETERS
//  SCAN_DIV    100000  clk cycles per scan tick (50MHz -> 500Hz); must be >= 2
//  DB_TICKS    4       stable ticks required to accept a press or a release; must be >= 1
//  FIFO_DEPTH  4       key FIFO entries; power of 2, >= 2
// PORTS
//  clk        in   1  system clock; all logic on rising edge
//  reset_n    in   1  synchronous, active-low reset
//  row        in   4  keypad rows, active-low (external pull-ups), asynchronous
//  col        out  4  column drive, active-low, exactly one bit low at any time
//  key_code   out  4  FIFO head: row_idx*4 + col_idx (0..15)
//  key_valid  out  1  FIFO not empty
//  key_ready  in   1  consumer pops head when key_valid && key_ready
//  overrun    out  1  sticky: a press was dropped because the FIFO was full
//  ovr_clr    in   1  clears overrun
//  key_held   out  1  a debounced key is currently held
// BEHAVIOUR
//  Reset (reset_n=0 at clk edge): col=4'b1110, FSM=SCAN, tick counter=0, DB counter=0,
//   FIFO empty (key_valid=0, key_code=0), overrun=0, key_held=0, row synchroniser=4'hF.
//  row passes a 2-flop synchroniser (rs); all decisions use rs only.
//  Tick: counter counts 0..SCAN_DIV-1; tick=1 for one clk when counter==SCAN_DIV-1.
//  Row hit: exactly one bit of rs low. Zero or >1 low bits = no hit (ghosting rejected).
//  FSM advances only on tick:
//   SCAN:  hit -> latch row_idx/col_idx, DB=1, go PRESS_DB (col frozen);
//          else rotate col left (1110->1101->1011->0111->1110).
//   PRESS_DB: same hit as latched -> DB++; when DB==DB_TICKS push code, go HELD.
//          any other rs value -> back to SCAN; col unchanged, rotates on next tick.
//   HELD:  rs==4'hF -> DB=1, go REL_DB; else stay.
//   REL_DB: rs==4'hF -> DB++; when DB==DB_TICKS go SCAN, rotate col.
//          rs!=4'hF -> back to HELD, DB=0.
//  key_held=1 in HELD and REL_DB.
//  Push occurs in the clk cycle of the accepting tick; code is visible on key_code with
//   key_valid=1 the following clk if FIFO was empty (press-to-valid = DB_TICKS ticks
//   after first hit tick, +1 clk).
//  FIFO: first-word-fall-through; key_code always shows the head entry.
//   Pop when key_valid && key_ready. Simultaneous push+pop: both happen, count unchanged.
//   Push when full and no pop in that cycle: entry dropped, overrun<=1.
//   Push when full with pop in the same cycle: accepted, no overrun.
//   key_ready while empty: ignored.
//  overrun: ovr_clr clears; a drop and ovr_clr in the same cycle -> overrun=1 (set wins).
//  Pointers are log2(FIFO_DEPTH) bits plus one wrap bit; full/empty from wrap-bit compare.
//  A held key produces exactly one code; no auto-repeat.
//  Reset mid-operation (any state, any FIFO level) returns everything to reset values
//   in that cycle; a key held through reset is re-detected as a new press.
// TESTING  (SCAN_DIV=4, DB_TICKS=2, FIFO_DEPTH=4)
//  Reset/idle: rows=F for 40 clk -> col cycles E,D,B,7 every 4 clk; key_valid=0, overrun=0.
//  Press: hold row=4'b1101 when col=4'b1011 (row1,col2) -> key_code=4'd6, key_valid=1
//   after 2 ticks; exactly one push while held; key_held=1 until 2 clean release ticks.
//  Bounce: row glitches low for 1 tick then high -> no push, scanning resumes.
//  Ghost: row=4'b1100 held -> no push, col keeps rotating.
//  FIFO: 5 presses with key_ready=0 -> 4 codes in order, overrun=1; pop all -> FIFO
//   empties in order; ovr_clr -> overrun=0; push+pop same clk at full -> no overrun.
//  Reset mid-HELD with FIFO holding 2 -> key_valid=0, col=1110; key still held -> new push.

Source files
------------

// File: rtl/keypad_scan_ctrl.sv
// ============================================================================
// Module      : keypad_scan_ctrl
// Description : 4x4 keypad scanner with tick-driven column drive, debounced
//               row detection and a first-word-fall-through key-code FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module keypad_scan_ctrl #(
  parameter int SCAN_DIV   = 100000,
  parameter int DB_TICKS   = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overrun,
  input  logic       ovr_clr,
  output logic       key_held
);

  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DB_W  = $clog2(DB_TICKS + 1);
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int PW    = AW + 1;

  localparam logic [1:0] ST_SCAN     = 2'd0;
  localparam logic [1:0] ST_PRESS_DB = 2'd1;
  localparam logic [1:0] ST_HELD     = 2'd2;
  localparam logic [1:0] ST_REL_DB   = 2'd3;

  localparam logic [3:0] COL_RESET   = 4'b1110;
  localparam logic [3:0] ROWS_IDLE   = 4'hF;

  logic [3:0]       rs1_q, rs1_d;
  logic [3:0]       rs_q, rs_d;
  logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]       state_q, state_d;
  logic [DB_W-1:0]  db_q, db_d;
  logic [1:0]       row_idx_q, row_idx_d;
  logic [1:0]       col_idx_q, col_idx_d;
  logic [3:0]       col_q, col_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [3:0]       mem_q [FIFO_DEPTH];
  logic [3:0]       mem_d [FIFO_DEPTH];
  logic             overrun_q, overrun_d;

  logic       tick;
  logic       hit;
  logic [1:0] hit_row;
  logic [1:0] cur_col_idx;
  logic       rotate;
  logic       push_req;
  logic       fifo_empty;
  logic       fifo_full;
  logic       pop;
  logic       do_push;
  logic       drop;

  // A hit needs exactly one low row; multi-row patterns are treated as ghosting.
  always_comb begin
    hit     = 1'b1;
    hit_row = 2'd0;
    case (rs_q)
      4'b1110: hit_row = 2'd0;
      4'b1101: hit_row = 2'd1;
      4'b1011: hit_row = 2'd2;
      4'b0111: hit_row = 2'd3;
      default: hit = 1'b0;
    endcase
  end

  always_comb begin
    cur_col_idx = 2'd0;
    case (col_q)
      4'b1101: cur_col_idx = 2'd1;
      4'b1011: cur_col_idx = 2'd2;
      4'b0111: cur_col_idx = 2'd3;
      default: cur_col_idx = 2'd0;
    endcase
  end

  assign tick = (tick_cnt_q == CNT_W'(SCAN_DIV - 1));

  always_comb begin
    rs1_d      = row;
    rs_d       = rs1_q;
    tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    state_d    = state_q;
    db_d       = db_q;
    row_idx_d  = row_idx_q;
    col_idx_d  = col_idx_q;
    rotate     = 1'b0;
    push_req   = 1'b0;
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (hit) begin
            row_idx_d = hit_row;
            col_idx_d = cur_col_idx;
            db_d      = DB_W'(1);
            state_d   = ST_PRESS_DB;
          end else begin
            rotate = 1'b1;
          end
        end
        ST_PRESS_DB: begin
          // A bounce returns to SCAN without rotating; the next tick rotates.
          if (hit && (hit_row == row_idx_q)) begin
            if (db_q == DB_W'(DB_TICKS)) begin
              push_req = 1'b1;
              state_d  = ST_HELD;
            end else begin
              db_d = db_q + DB_W'(1);
            end
          end else begin
            state_d = ST_SCAN;
          end
        end
        ST_HELD: begin
          if (rs_q == ROWS_IDLE) begin
            db_d    = DB_W'(1);
            state_d = ST_REL_DB;
          end
        end
        ST_REL_DB: begin
          if (rs_q == ROWS_IDLE) begin
            if (db_q == DB_W'(DB_TICKS)) begin
              state_d = ST_SCAN;
              rotate  = 1'b1;
            end else begin
              db_d = db_q + DB_W'(1);
            end
          end else begin
            db_d    = '0;
            state_d = ST_HELD;
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
    col_d = rotate ? {col_q[2:0], col_q[3]} : col_q;
  end

  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop        = !fifo_empty && key_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push    = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  always_comb begin
    mem_d = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = {row_idx_q, col_idx_q};
    end
    wr_ptr_d  = wr_ptr_q + PW'(do_push);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    overrun_d = drop | (overrun_q & ~ovr_clr);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rs1_q      <= ROWS_IDLE;
      rs_q       <= ROWS_IDLE;
      tick_cnt_q <= '0;
      state_q    <= ST_SCAN;
      db_q       <= '0;
      row_idx_q  <= 2'd0;
      col_idx_q  <= 2'd0;
      col_q      <= COL_RESET;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overrun_q  <= 1'b0;
    end else begin
      rs1_q      <= rs1_d;
      rs_q       <= rs_d;
      tick_cnt_q <= tick_cnt_d;
      state_q    <= state_d;
      db_q       <= db_d;
      row_idx_q  <= row_idx_d;
      col_idx_q  <= col_idx_d;
      col_q      <= col_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      overrun_q  <= overrun_d;
    end
  end

  // Storage needs no reset: key_code is gated to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign col       = col_q;
  assign key_valid = !fifo_empty;
  assign key_code  = fifo_empty ? 4'd0 : mem_q[rd_ptr_q[AW-1:0]];
  assign overrun   = overrun_q;
  assign key_held  = (state_q == ST_HELD) || (state_q == ST_REL_DB);

endmodule

`default_nettype wire
